// File: rtl/lif_spike_aer_encoder.sv
// LIF spike-vector to AER event encoder.
// Captures one spike vector per tick, walks its set bits lowest-first and
// queues {tick, neuron index} events into a FIFO drained over valid/ready.
module lif_spike_aer_encoder #(
   parameter int unsigned NUM_NEURONS = 10,
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned TICK_W      = 16,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned DROP_W      = 16
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NUM_NEURONS-1:0]          spike_vec_i,
   input  logic                            spike_valid_i,
   output logic                            spike_ready_o,
   output logic                            aer_valid_o,
   input  logic                            aer_ready_i,
   output logic [ADDR_W-1:0]               aer_addr_o,
   output logic [TICK_W-1:0]               aer_tick_o,
   output logic [TICK_W-1:0]               tick_cnt_o,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o,
   output logic                            overflow_o,
   output logic [DROP_W-1:0]               drop_cnt_o
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [NUM_NEURONS-1:0] scan_vec_q, scan_vec_d;
   logic [TICK_W-1:0]      scan_tick_q, scan_tick_d;
   logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;

   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   overflow_q, overflow_d;
   logic [DROP_W-1:0]      drop_cnt_q, drop_cnt_d;

   logic [ADDR_W-1:0]      mem_addr [FIFO_DEPTH];
   logic [TICK_W-1:0]      mem_tick [FIFO_DEPTH];

   logic [ADDR_W-1:0]      sel_idx;
   logic                   sel_found;
   logic                   push_req;
   logic                   push;
   logic                   pop;
   logic                   drop;
   logic                   full;

   // Lowest set bit of the vector being scanned.
   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
         if (!sel_found && scan_vec_q[i]) begin
            sel_found = 1'b1;
            sel_idx   = ADDR_W'(i);
         end
      end
   end

   // FSM next state, capture of the spike vector and per-cycle event generation.
   always_comb begin
      state_d       = state_q;
      scan_vec_d    = scan_vec_q;
      scan_tick_d   = scan_tick_q;
      tick_cnt_d    = tick_cnt_q;
      push_req      = 1'b0;
      spike_ready_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            spike_ready_o = 1'b1;
            if (spike_valid_i) begin
               scan_vec_d  = spike_vec_i;
               scan_tick_d = tick_cnt_q;
               tick_cnt_d  = tick_cnt_q + TICK_W'(1);
               if (spike_vec_i != '0) state_d = SCAN;
            end
         end
         SCAN: begin
            push_req = 1'b1;
            // v & (v-1) clears exactly the lowest set bit, matching sel_idx.
            scan_vec_d = scan_vec_q & (scan_vec_q - NUM_NEURONS'(1));
            if (scan_vec_d == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FIFO push/pop/drop decisions and bookkeeping.
   always_comb begin
      full       = (count_q == CNT_W'(FIFO_DEPTH));
      pop        = (count_q != '0) && aer_ready_i;
      push       = push_req && (!full || pop);
      drop       = push_req && !push;
      wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d    = count_q;
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      overflow_d = overflow_q | drop;
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_W'(1);
   end

   // State, counter and pointer registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         scan_vec_q  <= '0;
         scan_tick_q <= '0;
         tick_cnt_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         scan_vec_q  <= scan_vec_d;
         scan_tick_q <= scan_tick_d;
         tick_cnt_q  <= tick_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   // Event storage; contents are only visible while count is non-zero.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_addr[wr_ptr_q] <= sel_idx;
         mem_tick[wr_ptr_q] <= scan_tick_q;
      end
   end

   assign aer_valid_o  = (count_q != '0);
   assign aer_addr_o   = aer_valid_o ? mem_addr[rd_ptr_q] : '0;
   assign aer_tick_o   = aer_valid_o ? mem_tick[rd_ptr_q] : '0;
   assign tick_cnt_o   = tick_cnt_q;
   assign fifo_count_o = count_q;
   assign overflow_o   = overflow_q;
   assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_lif_spike_aer_encoder.sv
// Scoreboard bench for lif_spike_aer_encoder: directed strobes push expected
// events; a negedge monitor pops and compares on each handshake.
module tb_lif_spike_aer_encoder;

   localparam int unsigned NN = 10;
   localparam int unsigned AW = 4;
   localparam int unsigned TW = 16;
   localparam int unsigned FD = 16;
   localparam int unsigned DW = 16;

   typedef struct {
      int unsigned tick;
      int unsigned addr;
   } ev_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [NN-1:0]   spike_vec;
   logic            spike_valid;
   logic            spike_ready;
   logic            aer_valid;
   logic            aer_ready;
   logic [AW-1:0]   aer_addr;
   logic [TW-1:0]   aer_tick;
   logic [TW-1:0]   tick_cnt;
   logic [$clog2(FD):0] fifo_count;
   logic            overflow;
   logic [DW-1:0]   drop_cnt;

   int   errors = 0;
   int   checks = 0;
   ev_t  exp_q[$];

   lif_spike_aer_encoder #(
      .NUM_NEURONS(NN), .ADDR_W(AW), .TICK_W(TW), .FIFO_DEPTH(FD), .DROP_W(DW)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .spike_vec_i(spike_vec), .spike_valid_i(spike_valid), .spike_ready_o(spike_ready),
      .aer_valid_o(aer_valid), .aer_ready_i(aer_ready),
      .aer_addr_o(aer_addr), .aer_tick_o(aer_tick),
      .tick_cnt_o(tick_cnt), .fifo_count_o(fifo_count),
      .overflow_o(overflow), .drop_cnt_o(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: any handshake seen at negedge completes on the next posedge.
   always @(negedge clk) begin
      if (!rst && aer_valid && aer_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got addr %0d tick %0d expected none", aer_addr, aer_tick);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            check("aer_addr", aer_addr, e.addr);
            check("aer_tick", aer_tick, e.tick);
         end
      end
   end

   // Strobe a vector for one edge; queue the first npush set bits as expected events.
   task automatic strobe(input logic [NN-1:0] vec, input int unsigned tick, input int unsigned npush);
      int unsigned pushed = 0;
      for (int i = 0; i < NN; i++) begin
         if (vec[i] && pushed < npush) begin
            ev_t e;
            e.tick = tick;
            e.addr = i;
            exp_q.push_back(e);
            pushed++;
         end
      end
      spike_vec   = vec;
      spike_valid = 1'b1;
      @(posedge clk); #1;
      spike_valid = 1'b0;
      spike_vec   = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_valid", aer_valid, 0);
      check("rst_ready", spike_ready, 1);
      check("rst_tick", tick_cnt, 0);
      check("rst_count", fifo_count, 0);
      check("rst_addr", aer_addr, 0);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!spike_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!spike_ready) check(name, 0, 1);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (aer_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, aer_valid, 0);
   endtask

   initial begin
      rst = 1'b1;
      spike_vec = '0;
      spike_valid = 1'b0;
      aer_ready = 1'b1;
      @(posedge clk); #1;

      // Basic vector, latency and ordering.
      do_reset();
      strobe(10'b0000100101, 0, 10);
      check("t1_valid_e0", aer_valid, 0);
      check("t1_tick_cnt", tick_cnt, 1);
      check("t1_ready_scan", spike_ready, 0);
      @(posedge clk); #1;
      check("t1_valid_e1", aer_valid, 1);
      check("t1_addr_e1", aer_addr, 0);
      @(posedge clk); #1;
      check("t1_addr_e2", aer_addr, 2);
      @(posedge clk); #1;
      check("t1_addr_e3", aer_addr, 5);
      @(posedge clk); #1;
      check("t1_valid_e4", aer_valid, 0);
      check("t1_ready_idle", spike_ready, 1);

      // Zero vectors: counted, no events.
      do_reset();
      repeat (3) begin
         strobe('0, 0, 0);
         check("t2_ready", spike_ready, 1);
         check("t2_valid", aer_valid, 0);
      end
      check("t2_tick_cnt", tick_cnt, 3);

      // Overflow with consumer stalled.
      do_reset();
      aer_ready = 1'b0;
      strobe(10'h3FF, 0, 10);
      wait_idle("t3_idle_timeout_a");
      check("t3_count_a", fifo_count, 10);
      strobe(10'h3FF, 1, 6);
      wait_idle("t3_idle_timeout_b");
      check("t3_count_b", fifo_count, 16);
      check("t3_overflow", overflow, 1);
      check("t3_drop_cnt", drop_cnt, 4);

      // Full FIFO, consumer resumes during SCAN: push+pop each cycle.
      strobe(10'h3FF, 2, 10);
      aer_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("t4_count_full", fifo_count, 16);
      end
      check("t4_drop_cnt", drop_cnt, 4);
      wait_drain("t4_drain");
      check("t4_count_empty", fifo_count, 0);
      check("t4_overflow", overflow, 1);
      check("t4_tick_cnt", tick_cnt, 3);

      // Strobe while scanning is ignored.
      do_reset();
      strobe(10'h3FF, 0, 10);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("t5_ready_busy", spike_ready, 0);
      strobe(10'h001, 0, 0);
      wait_idle("t5_idle_timeout");
      wait_drain("t5_drain");
      check("t5_tick_cnt", tick_cnt, 1);
      check("t5_drop_cnt", drop_cnt, 0);

      // Reset mid-scan with queued events.
      do_reset();
      aer_ready = 1'b0;
      strobe(10'h3FF, 0, 0);
      repeat (5) begin
         @(posedge clk); #1;
      end
      check("t6_count_pre", fifo_count, 5);
      rst = 1'b1;
      #1;
      check("t6_valid", aer_valid, 0);
      check("t6_count", fifo_count, 0);
      check("t6_tick_cnt", tick_cnt, 0);
      check("t6_drop_cnt", drop_cnt, 0);
      check("t6_overflow", overflow, 0);
      check("t6_ready", spike_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      aer_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("t6_valid_after", aer_valid, 0);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lif_spike_aer_encoder.md
Name: lif_spike_aer_encoder

Overview:
- Downstream stage of the LIF neuron array (Neuromorphic_design).
- Once per simulation tick it captures the array's postsynaptic spike vector.
- It serializes the set bits into address-event (AER) words {tick, neuron index}, lowest index first.
- Events are buffered in a FIFO and driven out over a valid/ready stream to the host/monitor side.

Parameters:
- NUM_NEURONS, 10, width of the spike vector (one bit per postsynaptic neuron).
- ADDR_W, 4, neuron index width; must satisfy 2^ADDR_W >= NUM_NEURONS.
- TICK_W, 16, timestamp width; the counter wraps modulo 2^TICK_W.
- FIFO_DEPTH, 16, event FIFO entries; must be a power of two, minimum 2.
- DROP_W, 16, width of the saturating dropped-event counter.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- spike_vec_i  in  NUM_NEURONS  spike vector from the LIF array; bit n = neuron n fired this tick.
- spike_valid_i  in  1  one-cycle strobe marking spike_vec_i valid at end of tick.
- spike_ready_o  out  1  encoder can accept a vector (FSM in IDLE).
- aer_valid_o  out  1  FIFO head holds an event.
- aer_ready_i  in  1  consumer accepts the head event.
- aer_addr_o  out  ADDR_W  neuron index of the head event.
- aer_tick_o  out  TICK_W  timestamp of the head event.
- tick_cnt_o  out  TICK_W  number of vectors accepted since reset, modulo 2^TICK_W.
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow_o  out  1  sticky flag; set when any event has been dropped.
- drop_cnt_o  out  DROP_W  dropped events, saturating at all-ones.

Behaviour:
- Reset (async assert, sync to clock edge on release):
  - FSM to IDLE; FIFO emptied.
  - All counters 0, overflow_o 0, aer_valid_o 0, aer_addr_o 0, aer_tick_o 0, spike_ready_o 1 after reset release.
- Reset asserted mid-scan or with a non-empty FIFO discards all pending events immediately; there is no partial output.
- FSM states are IDLE and SCAN.
- IDLE:
  - spike_ready_o = 1.
  - On spike_valid_i=1, latch spike_vec_i into scan_vec and latch tick_cnt into scan_tick. tick_cnt then increments (wrap).
  - If the latched vector is non-zero, go to SCAN; if it is zero, stay in IDLE and generate no events.
- SCAN:
  - spike_ready_o = 0.
  - Each cycle, select the lowest set bit n of scan_vec and generate event {scan_tick, n}, then clear bit n.
  - When the cleared vector becomes zero, return to IDLE on the same edge that pushes the last event.
  - A vector with k set bits occupies exactly k SCAN cycles.
- spike_valid_i while spike_ready_o=0 is ignored: the vector is not latched, tick_cnt does not increment, and no drop is counted. The upstream stage must only strobe when ready.
- FIFO push rule:
  - An event is written when count < FIFO_DEPTH, or when a pop occurs in the same cycle (push and pop together leave count unchanged).
  - Otherwise the event is dropped: the bit is still cleared and scanning continues (no stall), overflow_o is set, and drop_cnt_o increments, saturating.
- FIFO pop: occurs when aer_valid_o && aer_ready_i. The head advances on that edge.
- aer_valid_o = (count != 0). aer_addr_o and aer_tick_o show the head entry; they are held stable while aer_valid_o=1 and aer_ready_i=0.
- Latency:
  - Strobe accepted on edge E0.
  - First event pushed on edge E1.
  - aer_valid_o high in the cycle after E1 (2 cycles from strobe to first visible event when the FIFO starts empty).
- Read and write pointers wrap modulo FIFO_DEPTH. Occupancy is tracked by a separate count register.
- overflow_o and drop_cnt_o are cleared only by reset.
- Arithmetic: all counters are unsigned. tick_cnt wraps; drop_cnt saturates.

Test Plan:
- Reset, then strobe vector 0b0000100101 with aer_ready_i=1 -> events (tick 0, addr 0), (tick 0, addr 2), (tick 0, addr 5) on consecutive cycles; first aer_valid_o 2 cycles after the strobe; tick_cnt_o=1.
- Strobe all-zero vector 3 times -> no events; tick_cnt_o=3; spike_ready_o stays 1.
- aer_ready_i=0, strobe 0x3FF twice (second strobe when ready returns) -> 16 entries stored, 4 dropped; overflow_o=1, drop_cnt_o=4, fifo_count_o=16. Release ready -> addrs 0..9 at tick 0, then 0..5 at tick 1.
- FIFO full with aer_ready_i=1 during SCAN -> simultaneous push/pop, no drops, fifo_count_o stays 16.
- Strobe during SCAN (vector 0x3FF, second strobe on cycle 3) -> second strobe ignored; tick_cnt_o increments once only.
- Assert rst_i mid-SCAN with 5 events queued -> aer_valid_o=0 immediately, fifo_count_o=0, all counters 0, FSM IDLE.
